// File: rtl/decode_stage.sv
// decode_stage: registered MIPS instruction-decode stage.
//   Classifies the accepted word into a one-hot type vector, extracts
//   rs/rt/write-register/immediate fields and operand-read flags, and
//   registers the bundle with a one-cycle latency behind a valid/ready
//   handshake. A load-use hazard against the previously issued lw inserts
//   exactly one bubble. Illegal words bump a saturating counter.
// Ports:
//   clk, rst_n (async low), flush (sync kill of contents + hazard state)
//   in_valid/in_ready/in_instr/in_pc     upstream side
//   out_valid/out_ready/out_*            decoded bundle
//   err_count                            saturating illegal-instruction count
module decode_stage #(
  parameter  int EXT_ISA = 0,
  parameter  int CNT_W   = 8,
  localparam int TYPE_W  = (EXT_ISA != 0) ? 21 : 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TYPE_W-1:0] out_type,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_wreg,
  output logic [31:0]       out_imm32,
  output logic              out_uses_rs,
  output logic              out_uses_rt,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic {RUN, BUBBLE} st_t;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [4:0]        wreg;
    logic [31:0]       imm;
    logic              urs;
    logic              urt;
  } dec_t;

  localparam logic EXT = (EXT_ISA != 0);

  st_t        st, st_nx;
  dec_t       dec, q;
  logic [4:0] prev_ld;
  logic [20:0] tf;
  logic       r_arith, slot_free, hazard, accept, bubble;
  logic [31:0] pc4;

  // ---- combinational decode of the incoming word ----
  always_comb begin
    tf  = '0;
    pc4 = in_pc + 32'd4;
    if (in_instr[31:26] == 6'b000000) begin
      case (in_instr[5:0])
        6'b100001: tf[0]  = 1'b1;
        6'b100011: tf[1]  = 1'b1;
        6'b001000: tf[9]  = 1'b1;
        6'b000000: tf[10] = 1'b1;
        6'b100000: tf[12] = EXT;
        6'b100010: tf[13] = EXT;
        6'b100100: tf[14] = EXT;
        6'b100101: tf[15] = EXT;
        6'b101010: tf[16] = EXT;
        6'b001001: tf[20] = EXT;
        default:   ;
      endcase
    end else begin
      case (in_instr[31:26])
        6'b001101: tf[2]  = 1'b1;
        6'b100011: tf[3]  = 1'b1;
        6'b101011: tf[4]  = 1'b1;
        6'b000100: tf[5]  = 1'b1;
        6'b001111: tf[6]  = 1'b1;
        6'b000010: tf[7]  = 1'b1;
        6'b000011: tf[8]  = 1'b1;
        6'b001000: tf[17] = EXT;
        6'b001100: tf[18] = EXT;
        6'b000101: tf[19] = EXT;
        default:   ;
      endcase
    end
    // anything unmatched (including extended words in the base build) is err
    if (tf == '0) tf[11] = 1'b1;

    r_arith = tf[0] | tf[1] | (|tf[16:12]);

    dec.typ = tf[TYPE_W-1:0];

    if (r_arith | tf[10] | tf[20])                  dec.wreg = in_instr[15:11];
    else if (tf[2] | tf[3] | tf[6] | tf[17] | tf[18]) dec.wreg = in_instr[20:16];
    else if (tf[8])                                 dec.wreg = 5'd31;
    else                                            dec.wreg = 5'd0;

    if (tf[2] | tf[18])     dec.imm = {16'h0, in_instr[15:0]};
    else if (tf[6])         dec.imm = {in_instr[15:0], 16'h0};
    else if (tf[7] | tf[8]) dec.imm = {pc4[31:28], in_instr[25:0], 2'b00};
    else                    dec.imm = {{16{in_instr[15]}}, in_instr[15:0]};

    dec.urs = r_arith | tf[9] | tf[20] | tf[2] | tf[3] | tf[4] | tf[5] |
              tf[17] | tf[18] | tf[19];
    dec.urt = r_arith | tf[10] | tf[4] | tf[5] | tf[19];
  end

  // ---- handshake / hazard ----
  assign slot_free = !out_valid || out_ready;
  assign hazard    = in_valid && (prev_ld != 5'd0) &&
                     ((dec.urs && in_instr[25:21] == prev_ld) ||
                      (dec.urt && in_instr[20:16] == prev_ld));
  assign in_ready  = rst_n && slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;
  assign bubble    = (st == RUN) && hazard && slot_free && !flush;

  always_comb begin
    st_nx = st;
    if (flush)              st_nx = RUN;
    else if (st == BUBBLE)  st_nx = RUN;
    else if (bubble)        st_nx = BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RUN;
    else        st <= st_nx;
  end

  // ---- output register, hazard register, error counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      out_instr <= '0;
      out_pc    <= '0;
      prev_ld   <= '0;
      err_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      prev_ld   <= '0;
    end else if (slot_free) begin
      if (bubble) begin
        out_valid <= 1'b0;
        prev_ld   <= '0;
      end else if (accept) begin
        out_valid <= 1'b1;
        q         <= dec;
        out_instr <= in_instr;
        out_pc    <= in_pc;
        // only a just-issued lw can create a load-use dependency
        prev_ld   <= dec.typ[3] ? dec.wreg : 5'd0;
        if (dec.typ[11] && err_count != {CNT_W{1'b1}})
          err_count <= err_count + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_type    = q.typ;
  assign out_wreg    = q.wreg;
  assign out_imm32   = q.imm;
  assign out_uses_rs = q.urs;
  assign out_uses_rt = q.urt;
  assign out_rs      = out_instr[25:21];
  assign out_rt      = out_instr[20:16];

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances sharing stimulus (base ISA with a
// 2-bit counter, extended ISA with an 8-bit counter), each compared every
// cycle against a behavioural model, plus directed literal checks.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic [11:0] d0_type;
  logic [20:0] d1_type;
  logic [1:0]  d0_err;
  logic [7:0]  d1_err;

  logic        o_v[2], o_ir[2], o_urs[2], o_urt[2];
  logic [31:0] o_instr[2], o_pc[2], o_imm[2], o_type[2], o_err[2];
  logic [4:0]  o_rs[2], o_rt[2], o_wreg[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.EXT_ISA(0), .CNT_W(2)) d0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(o_ir[0]), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o_v[0]), .out_ready(out_ready), .out_type(d0_type),
    .out_instr(o_instr[0]), .out_pc(o_pc[0]), .out_rs(o_rs[0]), .out_rt(o_rt[0]),
    .out_wreg(o_wreg[0]), .out_imm32(o_imm[0]), .out_uses_rs(o_urs[0]),
    .out_uses_rt(o_urt[0]), .err_count(d0_err));

  decode_stage #(.EXT_ISA(1), .CNT_W(8)) d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(o_ir[1]), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(o_v[1]), .out_ready(out_ready), .out_type(d1_type),
    .out_instr(o_instr[1]), .out_pc(o_pc[1]), .out_rs(o_rs[1]), .out_rt(o_rt[1]),
    .out_wreg(o_wreg[1]), .out_imm32(o_imm[1]), .out_uses_rs(o_urs[1]),
    .out_uses_rt(o_urt[1]), .err_count(d1_err));

  assign o_type[0] = {20'h0, d0_type};
  assign o_type[1] = {11'h0, d1_type};
  assign o_err[0]  = {30'h0, d0_err};
  assign o_err[1]  = {24'h0, d1_err};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Type-membership sets, one bit per type index.
  localparam logic [31:0] S_RARITH = 32'h0001F003; // addu subu add sub and or slt
  localparam logic [31:0] S_WR_RD  = 32'h0011F403; // R-arith, sll, jalr
  localparam logic [31:0] S_WR_RT  = 32'h0006004C; // ori lw lui addi andi
  localparam logic [31:0] S_URS    = 32'h001FF23F;
  localparam logic [31:0] S_URT    = 32'h0009F433;
  localparam logic [31:0] S_ZEXT   = 32'h00040004; // ori andi

  typedef struct {
    logic        ov;
    logic [31:0] typ, instr, pc, imm;
    logic [4:0]  wreg, pl;
    logic        urs, urt;
    int          errc;
  } mst_t;

  mst_t m[2];

  function automatic bit inset(logic [31:0] s, int t);
    return s[t];
  endfunction

  function automatic int mtype(bit ext, logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'd0) begin
      case (fn)
        6'h21: return 0;
        6'h23: return 1;
        6'h08: return 9;
        6'h00: return 10;
        6'h20: return ext ? 12 : 11;
        6'h22: return ext ? 13 : 11;
        6'h24: return ext ? 14 : 11;
        6'h25: return ext ? 15 : 11;
        6'h2A: return ext ? 16 : 11;
        6'h09: return ext ? 20 : 11;
        default: return 11;
      endcase
    end
    case (op)
      6'h0D: return 2;
      6'h23: return 3;
      6'h2B: return 4;
      6'h04: return 5;
      6'h0F: return 6;
      6'h02: return 7;
      6'h03: return 8;
      6'h08: return ext ? 17 : 11;
      6'h0C: return ext ? 18 : 11;
      6'h05: return ext ? 19 : 11;
      default: return 11;
    endcase
  endfunction

  function automatic bit mhz(mst_t s, bit ext, logic v, logic [31:0] i);
    int t;
    t = mtype(ext, i);
    return v && s.pl != 0 &&
           ((inset(S_URS, t) && i[25:21] == s.pl) ||
            (inset(S_URT, t) && i[20:16] == s.pl));
  endfunction

  function automatic mst_t mstep(mst_t s, bit ext, int cmax, logic fl,
                                 logic v, logic rdy, logic [31:0] i, logic [31:0] pc);
    mst_t n;
    int t;
    logic [31:0] p4;
    n = s;
    t = mtype(ext, i);
    p4 = pc + 32'd4;
    if (fl) begin
      n.ov = 0; n.pl = 0;
    end else if (!s.ov || rdy) begin
      if (mhz(s, ext, v, i)) begin
        n.ov = 0; n.pl = 0;
      end else if (v) begin
        n.ov = 1; n.typ = 32'd1 << t; n.instr = i; n.pc = pc;
        n.urs = inset(S_URS, t); n.urt = inset(S_URT, t);
        if (inset(S_WR_RD, t))      n.wreg = i[15:11];
        else if (inset(S_WR_RT, t)) n.wreg = i[20:16];
        else if (t == 8)            n.wreg = 5'd31;
        else                        n.wreg = 5'd0;
        if (inset(S_ZEXT, t))       n.imm = {16'h0, i[15:0]};
        else if (t == 6)            n.imm = {i[15:0], 16'h0};
        else if (t == 7 || t == 8)  n.imm = {p4[31:28], i[25:0], 2'b00};
        else                        n.imm = {{16{i[15]}}, i[15:0]};
        n.pl = (t == 3) ? n.wreg : 5'd0;
        if (t == 11 && n.errc < cmax) n.errc++;
      end else begin
        n.ov = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        m[d] <= '{ov: 0, typ: 0, instr: 0, pc: 0, imm: 0, wreg: 0, pl: 0,
                   urs: 0, urt: 0, errc: 0};
    end else begin
      m[0] <= mstep(m[0], 1'b0, 3,   flush, in_valid, out_ready, in_instr, in_pc);
      m[1] <= mstep(m[1], 1'b1, 255, flush, in_valid, out_ready, in_instr, in_pc);
    end
  end

  // one compare process, away from the active edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d.valid", d), {31'h0, o_v[d]}, {31'h0, m[d].ov});
      chk($sformatf("d%0d.err", d), o_err[d], m[d].errc);
      chk($sformatf("d%0d.in_ready", d), {31'h0, o_ir[d]},
          {31'h0, rst_n && (!m[d].ov || out_ready) && !flush &&
                  !mhz(m[d], d == 1, in_valid, in_instr)});
      if (m[d].ov) begin
        chk($sformatf("d%0d.type", d), o_type[d], m[d].typ);
        chk($sformatf("d%0d.instr", d), o_instr[d], m[d].instr);
        chk($sformatf("d%0d.pc", d), o_pc[d], m[d].pc);
        chk($sformatf("d%0d.rs", d), {27'h0, o_rs[d]}, {27'h0, m[d].instr[25:21]});
        chk($sformatf("d%0d.rt", d), {27'h0, o_rt[d]}, {27'h0, m[d].instr[20:16]});
        chk($sformatf("d%0d.wreg", d), {27'h0, o_wreg[d]}, {27'h0, m[d].wreg});
        chk($sformatf("d%0d.imm", d), o_imm[d], m[d].imm);
        chk($sformatf("d%0d.urs", d), {31'h0, o_urs[d]}, {31'h0, m[d].urs});
        chk($sformatf("d%0d.urt", d), {31'h0, o_urt[d]}, {31'h0, m[d].urt});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(logic v, logic [31:0] i, logic [31:0] p);
    in_valid = v; in_instr = i; in_pc = p;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns[11];
    logic [5:0] ops[10];
    logic [4:0] a, b, c;
    int k;
    fns = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h09, 6'h3F};
    ops = '{6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h05};
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 9);
    if (k < 4)       return {6'h0, a, b, c, 5'($urandom), fns[$urandom_range(0, 10)]};
    else if (k < 9)  return {ops[$urandom_range(0, 9)], a, b, 16'($urandom)};
    else             return $urandom;
  endfunction

  initial begin
    int bub;
    bit found;
    flush = 0; in_valid = 0; out_ready = 1; in_instr = 0; in_pc = 0;
    #1 rst_n = 0;
    @(negedge clk); #1;
    chk("rst.valid", {31'h0, o_v[0]}, 32'h0);
    chk("rst.err", o_err[0], 32'h0);
    chk("rst.in_ready", {31'h0, o_ir[0]}, 32'h0);
    @(posedge clk); #1 rst_n = 1;

    // base decode
    put(1, 32'h00221821, 32'h3000);
    chk("addu.type", o_type[0], 32'h1);
    chk("addu.wreg", {27'h0, o_wreg[0]}, 32'd3);
    put(1, 32'h3421FFFF, 32'h3004);
    chk("ori.type", o_type[0], 32'h4);
    chk("ori.imm", o_imm[0], 32'h0000FFFF);
    put(1, 32'h3C011234, 32'h3008);
    chk("lui.type", o_type[0], 32'h40);
    chk("lui.imm", o_imm[0], 32'h12340000);
    put(1, 32'h0C000010, 32'h300C);
    chk("jal.type", o_type[0], 32'h100);
    chk("jal.imm", o_imm[0], 32'h00000040);
    chk("jal.wreg", {27'h0, o_wreg[0]}, 32'd31);

    // addi: illegal in base build, decoded in extended build
    put(1, 32'h2008FFFF, 32'h3010);
    chk("addi0.type", o_type[0], 32'h800);
    chk("addi0.err", o_err[0], 32'd1);
    chk("addi1.type", o_type[1], 32'h20000);
    chk("addi1.imm", o_imm[1], 32'hFFFFFFFF);
    chk("addi1.wreg", {27'h0, o_wreg[1]}, 32'd8);

    // load-use: lw $8 then addu $9,$8,$10 -> one bubble
    put(1, 32'h8D280000, 32'h3014);
    chk("lw.type", o_type[1], 32'h8);
    in_instr = 32'h010A4821; in_pc = 32'h3018;
    bub = 0; found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(posedge clk); #1;
      if (o_v[1] && o_type[1] == 32'h1) found = 1;
      else if (!o_v[1]) bub++;
    end
    chk("loaduse.seen", {31'h0, found}, 32'h1);
    chk("loaduse.bubbles", bub, 32'd1);

    // lw $8 then lui $8 -> no bubble
    put(1, 32'h8D280000, 32'h301C);
    put(1, 32'h3C080005, 32'h3020);
    chk("lwlui.valid", {31'h0, o_v[1]}, 32'h1);
    chk("lwlui.type", o_type[1], 32'h40);

    // back-pressure on a lw, then flush clears hazard state
    put(1, 32'h8D280000, 32'h3100);
    out_ready = 0; in_instr = 32'h010A4821; in_pc = 32'h3104;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold.valid", {31'h0, o_v[1]}, 32'h1);
      chk("hold.instr", o_instr[1], 32'h8D280000);
      chk("hold.in_ready", {31'h0, o_ir[1]}, 32'h0);
    end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush.valid", {31'h0, o_v[1]}, 32'h0);
    out_ready = 1;
    @(posedge clk); #1;
    chk("postflush.valid", {31'h0, o_v[1]}, 32'h1);
    chk("postflush.type", o_type[1], 32'h1);

    // counter saturation
    for (int k = 0; k < 5; k++) put(1, 32'hFC000000, 32'h3200 + 32'(4 * k));
    chk("sat.err0", o_err[0], 32'd3);
    chk("sat.err1", o_err[1], 32'd5);

    // reset mid-stream
    put(1, 32'h00221821, 32'h3300);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("midrst.valid", {31'h0, o_v[1]}, 32'h0);
    chk("midrst.err", o_err[0], 32'h0);
    chk("midrst.in_ready", {31'h0, o_ir[1]}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1;
    in_valid = 1; in_instr = 32'h3421FFFF; in_pc = 32'h3400;
    @(posedge clk); #1;
    chk("postrst.valid", {31'h0, o_v[1]}, 32'h1);
    chk("postrst.type", o_type[1], 32'h4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = rnd_instr();
      in_pc     = {$urandom, 2'b00};
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
